// File: rtl/handshake_arb_fifo_if.sv
// Bundle between the request sources / drain sink and handshake_arb_fifo.
// master = source+sink side, slave = the arbiter FIFO itself.
interface handshake_arb_fifo_if #(
    parameter int WIDTH = 32,
    parameter int CH    = 4,
    parameter int DEPTH = 4
) ();
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int NW = $clog2(DEPTH + 1);

    logic [CH-1:0]       sreq;
    logic [CH*WIDTH-1:0] sdin;
    logic [CH-1:0]       sack;
    logic                dbusy;
    logic                dvalid;
    logic [WIDTH-1:0]    dout;
    logic [CW-1:0]       dch;
    logic [NW-1:0]       fifo_cnt;

    modport master (
        output sreq, sdin, dbusy,
        input  sack, dvalid, dout, dch, fifo_cnt
    );

    modport slave (
        input  sreq, sdin, dbusy,
        output sack, dvalid, dout, dch, fifo_cnt
    );
endinterface

// File: rtl/handshake_arb_fifo.sv
// Multi-channel 4-phase req/ack capture with round-robin arbitration
// into a small FIFO that drains to one sink via dvalid/dbusy.
module handshake_arb_fifo #(
    parameter int WIDTH = 32,
    parameter int CH    = 4,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    handshake_arb_fifo_if.slave bus
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);

    logic [CH-1:0]       ack_q, ack_d;
    logic [CW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       wptr_q, rptr_q;
    logic [NW-1:0]       cnt_q, cnt_d;
    logic [CW+WIDTH-1:0] mem_q [DEPTH];
    logic                dvalid_q;
    logic [WIDTH-1:0]    dout_q;
    logic [CW-1:0]       dch_q;
    logic [CH-1:0]       cand;
    logic                gnt;
    logic [CW-1:0]       gidx;
    logic                pop;

    // Round-robin pick among idle requesters; full test uses registered count only
    always_comb begin
        cand = bus.sreq & ~ack_q;
        gnt  = 1'b0;
        gidx = '0;
        if (cnt_q != NW'(DEPTH)) begin
            for (int k = 0; k < CH; k++) begin
                if (!gnt && cand[(int'(ptr_q) + k) % CH]) begin
                    gnt  = 1'b1;
                    gidx = CW'((int'(ptr_q) + k) % CH);
                end
            end
        end
        ptr_d = gnt ? CW'((int'(gidx) + 1) % CH) : ptr_q;
        pop   = (cnt_q != '0) && !bus.dbusy;
        cnt_d = cnt_q + NW'(gnt) - NW'(pop);
    end

    // Per-channel FSM state register (0 = IDLE, 1 = ACK)
    always_ff @(posedge clk) begin
        if (rst) ack_q <= '0;
        else     ack_q <= ack_d;
    end

    // Per-channel next state: capture on grant, release once sreq drops
    always_comb begin
        ack_d = ack_q;
        for (int i = 0; i < CH; i++) begin
            if (ack_q[i]) ack_d[i] = bus.sreq[i];
            else          ack_d[i] = gnt && (gidx == CW'(i));
        end
    end

    // FSM outputs and registered sink-side outputs
    always_comb begin
        bus.sack     = ack_q;
        bus.dvalid   = dvalid_q;
        bus.dout     = dout_q;
        bus.dch      = dch_q;
        bus.fifo_cnt = cnt_q;
    end

    // Pointers, occupancy and pop register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            dvalid_q <= 1'b0;
            dout_q   <= '0;
            dch_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            dvalid_q <= pop;
            if (gnt) wptr_q <= wptr_q + PW'(1);
            if (pop) begin
                rptr_q          <= rptr_q + PW'(1);
                {dch_q, dout_q} <= mem_q[rptr_q];
            end
        end
    end

    // Storage array: word tagged with its source channel
    always_ff @(posedge clk) begin
        if (!rst && gnt)
            mem_q[wptr_q] <= {gidx, bus.sdin[int'(gidx)*WIDTH +: WIDTH]};
    end
endmodule

// File: tb/tb_handshake_arb_fifo.sv
// Scoreboard bench for handshake_arb_fifo: directed handshakes push
// expected words, a negedge monitor pops and compares on each dvalid.
module tb_handshake_arb_fifo;
    localparam int W  = 32;
    localparam int CH = 4;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst;
    logic rnd = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [W+1:0] exp_q [$];
    logic [W+1:0] e;

    handshake_arb_fifo_if #(.WIDTH(W), .CH(CH), .DEPTH(D)) bus ();

    handshake_arb_fifo #(.WIDTH(W), .CH(CH), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) bus.dbusy = 1'($urandom_range(0, 1));
    endtask

    task automatic set_data(input int ch, input logic [W-1:0] v);
        bus.sdin[ch*W +: W] = v;
    endtask

    task automatic expect_word(input int ch, input logic [W-1:0] v);
        exp_q.push_back({2'(ch), v});
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_sack"}, 64'(bus.sack), 64'd0);
        check({nm, "_dvalid"}, 64'(bus.dvalid), 64'd0);
        check({nm, "_dout"}, 64'(bus.dout), 64'd0);
        check({nm, "_dch"}, 64'(bus.dch), 64'd0);
        check({nm, "_cnt"}, 64'(bus.fifo_cnt), 64'd0);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.fifo_cnt != 0) && n < 60) begin
            tick();
            n++;
        end
        tick();
        check({nm, "_drain_timeout"}, 64'(n < 60), 64'd1);
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        exp_q.delete();
        tick();
        check_zero(nm);
        rst = 1'b0;
    endtask

    // Monitor: every dvalid pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (bus.dvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_dvalid: got dout=%0h dch=%0d want none",
                         bus.dout, bus.dch);
            end else begin
                e = exp_q.pop_front();
                check("mon_dout", 64'(bus.dout), 64'(e[W-1:0]));
                check("mon_dch", 64'(bus.dch), 64'(e[W+1:W]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        logic [W-1:0] v;
        rst = 1'b1;
        bus.sreq = '0;
        bus.sdin = '0;
        bus.dbusy = 1'b0;
        tick();
        tick();
        check_zero("rst0");
        rst = 1'b0;

        // 1: single word on channel 2
        set_data(2, 32'hDEAD_BEEF);
        bus.sreq = 4'b0100;
        expect_word(2, 32'hDEAD_BEEF);
        tick();
        check("t1_sack", 64'(bus.sack), 64'h4);
        check("t1_cnt", 64'(bus.fifo_cnt), 64'd1);
        bus.sreq = '0;
        tick();
        check("t1_sack_drop", 64'(bus.sack), 64'h0);
        check("t1_cnt_pop", 64'(bus.fifo_cnt), 64'd0);
        drain("t1");

        // 2: round robin from ptr=0
        do_reset("rst1");
        for (int i = 0; i < CH; i++) begin
            set_data(i, W'(i));
            expect_word(i, W'(i));
        end
        bus.sreq = 4'hF;
        tick();
        check("t2_g0", 64'(bus.sack), 64'h1);
        tick();
        check("t2_g1", 64'(bus.sack), 64'h3);
        tick();
        check("t2_g2", 64'(bus.sack), 64'h7);
        tick();
        check("t2_g3", 64'(bus.sack), 64'hF);
        bus.sreq = '0;
        tick();
        check("t2_clr", 64'(bus.sack), 64'h0);
        set_data(0, 32'h10);
        set_data(3, 32'h13);
        expect_word(0, 32'h10);
        expect_word(3, 32'h13);
        bus.sreq = 4'b1001;
        tick();
        check("t2_r0", 64'(bus.sack), 64'h1);
        tick();
        check("t2_r3", 64'(bus.sack), 64'h9);
        bus.sreq = '0;
        tick();
        drain("t2");

        // 3: fill to DEPTH with sink stalled
        bus.dbusy = 1'b1;
        for (int i = 0; i < CH; i++) begin
            set_data(i, W'(32'h100 + i));
            expect_word(i, W'(32'h100 + i));
        end
        bus.sreq = 4'hF;
        repeat (4) tick();
        check("t3_full", 64'(bus.fifo_cnt), 64'd4);
        bus.sreq = '0;
        tick();
        set_data(0, 32'h200);
        set_data(1, 32'h201);
        expect_word(0, 32'h200);
        expect_word(1, 32'h201);
        bus.sreq = 4'b0011;
        repeat (3) tick();
        check("t3_hold_cnt", 64'(bus.fifo_cnt), 64'd4);
        check("t3_hold_sack", 64'(bus.sack), 64'h0);
        bus.dbusy = 1'b0;
        tick();
        check("t3_pop_cnt", 64'(bus.fifo_cnt), 64'd3);
        check("t3_pop_sack", 64'(bus.sack), 64'h0);
        tick();
        check("t3_a0_sack", 64'(bus.sack), 64'h1);
        check("t3_a0_cnt", 64'(bus.fifo_cnt), 64'd3);
        tick();
        check("t3_a1_sack", 64'(bus.sack), 64'h3);
        bus.sreq = '0;
        tick();
        drain("t3");

        // 4: push and pop in the same cycle at count 2
        bus.dbusy = 1'b1;
        set_data(0, 32'h300);
        set_data(1, 32'h301);
        expect_word(0, 32'h300);
        expect_word(1, 32'h301);
        bus.sreq = 4'b0011;
        tick();
        tick();
        bus.sreq = '0;
        tick();
        check("t4_pre_cnt", 64'(bus.fifo_cnt), 64'd2);
        set_data(2, 32'h302);
        expect_word(2, 32'h302);
        bus.sreq = 4'b0100;
        bus.dbusy = 1'b0;
        tick();
        check("t4_cnt", 64'(bus.fifo_cnt), 64'd2);
        check("t4_dvalid", 64'(bus.dvalid), 64'd1);
        check("t4_sack", 64'(bus.sack), 64'h4);
        bus.sreq = '0;
        drain("t4");

        // 5: reset with three words queued and channel 1 holding sreq
        bus.dbusy = 1'b1;
        for (int i = 0; i < 3; i++) set_data(i, W'(32'h400 + i));
        bus.sreq = 4'b0111;
        repeat (3) tick();
        check("t5_pre_cnt", 64'(bus.fifo_cnt), 64'd3);
        check("t5_pre_sack", 64'(bus.sack), 64'h7);
        bus.sreq = 4'b0010;
        do_reset("t5_rst");
        bus.dbusy = 1'b0;
        expect_word(1, 32'h401);
        tick();
        check("t5_recap", 64'(bus.sack), 64'h2);
        check("t5_recap_cnt", 64'(bus.fifo_cnt), 64'd1);
        bus.sreq = '0;
        drain("t5");

        // 6: 3*DEPTH words with random sink stalls
        rnd = 1'b1;
        for (int n = 0; n < 3 * D; n++) begin
            v = $urandom;
            set_data(n % CH, v);
            expect_word(n % CH, v);
            bus.sreq[n % CH] = 1'b1;
            k = 0;
            while (!bus.sack[n % CH] && k < 50) begin
                tick();
                k++;
            end
            check("t6_ack_timeout", 64'(k < 50), 64'd1);
            check("t6_cnt_range", 64'(bus.fifo_cnt <= D), 64'd1);
            bus.sreq[n % CH] = 1'b0;
            while (bus.sack[n % CH] && k < 100) begin
                tick();
                k++;
            end
        end
        rnd = 1'b0;
        bus.dbusy = 1'b0;
        drain("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
